hs_spi_master_avmm_s: RTL and testbench

Quad-SPI master that terminates an Avalon-MM slave port and converts each single-word read or write into one framed transaction on the 4-bit SCK/CSn/MOSI/MISO link. It is the initiating end of the link whose far end is `hs_spi_slave_avmm_m`. It sits in `top`, between the local AVMM fabric and the board SPI pins, and presents remote registers as a 32-bit memory-mapped window.

---
 rtl/hs_spi_pkg.sv | 17 +
 rtl/hs_spi_master_avmm_s_if.sv | 23 ++
 rtl/hs_spi_sck_gen.sv | 38 +++
 rtl/hs_spi_master_avmm_s.sv | 143 ++++++++++++++
 tb/tb_hs_spi_master_avmm_s.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hs_spi_pkg.sv
// rtl/hs_spi_pkg.sv - shared constants and state type for the quad-SPI AVMM bridge
package hs_spi_pkg;
    localparam int         SPI_W        = 4;
    localparam logic [7:0] CMD_WR       = 8'h80;
    localparam logic [7:0] CMD_RD       = 8'h00;
    localparam int         HDR_NIBBLES  = 6;
    localparam int         DATA_NIBBLES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_TURN,
        ST_WDATA,
        ST_RDATA,
        ST_GAP
    } spi_m_state_t;
endpackage

// File: rtl/hs_spi_master_avmm_s_if.sv
// rtl/hs_spi_master_avmm_s_if.sv - Avalon-MM single-word bus between fabric and SPI master
interface hs_spi_master_avmm_s_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic          readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/hs_spi_sck_gen.sv
// rtl/hs_spi_sck_gen.sv - SCK divider with rise/fall strobes flagging the edge on which SCK toggles
module hs_spi_sck_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);
    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_sck;
    logic          w_tick;

    assign w_tick = i_run && (r_cnt == LAST);
    assign o_rise = w_tick && !r_sck;
    assign o_fall = w_tick &&  r_sck;
    assign o_sck  = r_sck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!i_run) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/hs_spi_master_avmm_s.sv
// rtl/hs_spi_master_avmm_s.sv - AVMM slave that turns each word access into one quad-SPI frame
module hs_spi_master_avmm_s
    import hs_spi_pkg::*;
#(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int SPI_W  = 4,
    parameter int DIV    = 2,
    parameter int TA     = 4,
    parameter int CS_GAP = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hs_spi_master_avmm_s_if.slave avs,
    output logic                  SCK,
    output logic                  CSn,
    output logic [SPI_W-1:0]      MOSI,
    input  logic [SPI_W-1:0]      MISO
);
    localparam int         TXW      = (HDR_NIBBLES + DATA_NIBBLES) * SPI_W;
    localparam logic [7:0] HDR_END  = 8'(HDR_NIBBLES - 1);
    localparam logic [7:0] TURN_END = 8'(HDR_NIBBLES + TA - 1);
    localparam logic [7:0] WR_END   = 8'(HDR_NIBBLES + DATA_NIBBLES - 1);
    localparam logic [7:0] RD_END   = 8'(HDR_NIBBLES + TA + DATA_NIBBLES - 1);
    localparam logic [7:0] GAP_INIT = 8'(CS_GAP - 1);

    spi_m_state_t     r_state;
    logic             r_waitreq;
    logic             r_csn;
    logic [SPI_W-1:0] r_mosi;
    logic             r_run;
    logic             r_start;
    logic             r_is_wr;
    logic [TXW-1:0]   r_tx;
    logic [DW-1:0]    r_rx;
    logic [DW-1:0]    r_readdata;
    logic             r_rdv;
    logic [7:0]       r_nib;
    logic [7:0]       r_gap;

    logic             w_sck;
    logic             w_rise;
    logic             w_fall;
    logic [15:0]      w_addr16;
    logic [7:0]       w_last;

    hs_spi_sck_gen #(.DIV(DIV)) u_sck_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_run  (r_run),
        .o_sck  (w_sck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_comb begin
        w_addr16         = '0;
        w_addr16[AW-1:0] = avs.address;
    end

    assign w_last = r_is_wr ? WR_END : RD_END;

    assign SCK               = w_sck;
    assign CSn               = r_csn;
    assign MOSI              = r_mosi;
    assign avs.waitrequest   = r_waitreq;
    assign avs.readdata      = r_readdata;
    assign avs.readdatavalid = r_rdv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_waitreq  <= 1'b0;
            r_csn      <= 1'b1;
            r_mosi     <= '0;
            r_run      <= 1'b0;
            r_start    <= 1'b0;
            r_is_wr    <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_readdata <= '0;
            r_rdv      <= 1'b0;
            r_nib      <= '0;
            r_gap      <= '0;
        end else begin
            r_rdv <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // write wins when both strobes are up
                    if (avs.read || avs.write) begin
                        r_waitreq <= 1'b1;
                        r_is_wr   <= avs.write;
                        r_tx      <= avs.write ? TXW'({CMD_WR, w_addr16, avs.writedata})
                                               : TXW'({CMD_RD, w_addr16, {DW{1'b0}}});
                        r_start   <= 1'b1;
                        r_nib     <= '0;
                        r_state   <= ST_HDR;
                    end
                end
                ST_GAP: begin
                    if (r_gap == '0) begin
                        r_waitreq <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap - 8'd1;
                    end
                end
                default: begin
                    // one setup cycle after accept, then CSn drops with the first nibble already driven
                    if (r_start) begin
                        r_start <= 1'b0;
                        r_csn   <= 1'b0;
                        r_run   <= 1'b1;
                        r_mosi  <= r_tx[TXW-1 -: SPI_W];
                        r_tx    <= r_tx << SPI_W;
                    end else if (w_fall) begin
                        if (r_nib == w_last) begin
                            r_csn   <= 1'b1;
                            r_run   <= 1'b0;
                            r_mosi  <= '0;
                            r_gap   <= GAP_INIT;
                            r_state <= ST_GAP;
                            if (!r_is_wr) begin
                                r_readdata <= r_rx;
                                r_rdv      <= 1'b1;
                            end
                        end else begin
                            r_mosi <= r_tx[TXW-1 -: SPI_W];
                            r_tx   <= r_tx << SPI_W;
                            r_nib  <= r_nib + 8'd1;
                            if (r_state == ST_HDR && r_nib == HDR_END)
                                r_state <= r_is_wr ? ST_WDATA : ((TA == 0) ? ST_RDATA : ST_TURN);
                            if (r_state == ST_TURN && r_nib == TURN_END)
                                r_state <= ST_RDATA;
                        end
                    end
                    if (w_rise && r_state == ST_RDATA)
                        r_rx <= {r_rx[DW-SPI_W-1:0], MISO};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hs_spi_master_avmm_s.sv
// tb/tb_hs_spi_master_avmm_s.sv - scoreboard bench with a behavioural SPI slave and register memory
module tb_hs_spi_master_avmm_s;
    localparam int TA     = 4;
    localparam int CS_GAP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hs_spi_master_avmm_s_if #(.AW(10), .DW(32)) bus0 ();
    hs_spi_master_avmm_s_if #(.AW(10), .DW(32)) bus1 ();

    logic       sck0, csn0, sck1, csn1;
    logic [3:0] mosi0, mosi1;
    logic [3:0] miso = 4'h0;

    hs_spi_master_avmm_s #(.AW(10), .DW(32), .SPI_W(4), .DIV(2), .TA(TA), .CS_GAP(CS_GAP)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .avs(bus0.slave),
        .SCK(sck0), .CSn(csn0), .MOSI(mosi0), .MISO(miso)
    );

    hs_spi_master_avmm_s #(.AW(10), .DW(32), .SPI_W(4), .DIV(1), .TA(TA), .CS_GAP(CS_GAP)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .avs(bus1.slave),
        .SCK(sck1), .CSn(csn1), .MOSI(mosi1), .MISO(miso)
    );

    bit          sel = 1'b0;
    logic        m_sck, m_csn, m_wreq, m_rdv;
    logic [3:0]  m_mosi;
    logic [31:0] m_rdata;
    assign m_sck   = sel ? sck1  : sck0;
    assign m_csn   = sel ? csn1  : csn0;
    assign m_mosi  = sel ? mosi1 : mosi0;
    assign m_wreq  = sel ? bus1.waitrequest   : bus0.waitrequest;
    assign m_rdv   = sel ? bus1.readdatavalid : bus0.readdatavalid;
    assign m_rdata = sel ? bus1.readdata      : bus0.readdata;

    typedef struct {
        logic [71:0] nib;
        int          n;
        int          div;
    } frame_t;

    frame_t      exp_fr[$];
    logic [31:0] exp_rd[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          stray   = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push_frame(input logic [71:0] nib, input int n, input int div);
        frame_t f;
        f.nib = nib;
        f.n   = n;
        f.div = div;
        exp_fr.push_back(f);
    endtask

    // Monitor and SPI slave model: captures MOSI on SCK rise, serves MISO after SCK fall
    int          cyc = 0, rc = 0, low = 0, last_rise = 0, gap_cnt = -1, wcnt = 0, pend_wait = 0;
    bit          prev_csn = 1'b1, prev_sck = 1'b0, prev_wreq = 1'b0, in_frame = 1'b0, per_ok = 1'b1;
    bit          fr_wr = 1'b0;
    logic [71:0] cap = '0;
    logic [15:0] fr_addr = '0;
    logic [31:0] mem [int];

    always @(negedge clk) begin
        int          j;
        logic [31:0] rd_word;
        frame_t      f;
        cyc++;
        if (!rst_n) begin
            in_frame  = 1'b0;
            rc        = 0;
            prev_csn  = 1'b1;
            prev_sck  = 1'b0;
            prev_wreq = 1'b0;
            wcnt      = 0;
            gap_cnt   = -1;
            miso      = 4'h0;
        end else begin
            if (gap_cnt >= 0) gap_cnt++;
            if (m_wreq) wcnt++;
            else if (prev_wreq) begin
                chk("waitrequest_high_cycles", 72'(wcnt), 72'(pend_wait));
                chk("csn_rise_to_ready", 72'(gap_cnt), 72'(CS_GAP));
                wcnt    = 0;
                gap_cnt = -1;
            end
            if (prev_csn && !m_csn) begin
                in_frame = 1'b1;
                rc       = 0;
                cap      = '0;
                low      = 0;
                per_ok   = 1'b1;
                fr_wr    = 1'b0;
                miso     = 4'h0;
            end
            if (!m_csn) low++;
            if (m_sck && !prev_sck) begin
                if (m_csn) stray++;
                else begin
                    if (rc > 0 && (cyc - last_rise) != (sel ? 2 : 4)) per_ok = 1'b0;
                    last_rise = cyc;
                    cap = {cap[67:0], m_mosi};
                    rc++;
                    if (rc == 6) begin
                        fr_addr = cap[15:0];
                        fr_wr   = cap[23];
                    end
                end
            end
            if (!m_sck && prev_sck && !m_csn) begin
                j = rc - (6 + TA);
                rd_word = mem.exists(int'(fr_addr)) ? mem[int'(fr_addr)] : 32'h0;
                if (!fr_wr && rc >= 6 && j >= 0 && j < 8) miso = 4'(rd_word >> (28 - 4 * j));
                else miso = 4'h0;
            end
            if (!prev_csn && m_csn && in_frame) begin
                in_frame = 1'b0;
                miso     = 4'h0;
                if (exp_fr.size() == 0) stray++;
                else begin
                    f = exp_fr.pop_front();
                    chk("frame_sck_count", 72'(rc), 72'(f.n));
                    chk("frame_mosi_nibbles", cap, f.nib);
                    chk("csn_low_cycles", 72'(low), 72'(2 * f.div * f.n));
                    chk("sck_period", 72'(per_ok), 72'(1));
                    pend_wait = 1 + 2 * f.div * f.n + CS_GAP;
                end
                if (fr_wr) mem[int'(fr_addr)] = cap[31:0];
                gap_cnt = 0;
            end
            if (m_rdv) begin
                chk("rdv_with_csn_rise", 72'({m_csn, prev_csn}), 72'(2'b10));
                if (exp_rd.size() == 0) stray++;
                else chk("readdata", 72'(m_rdata), 72'(exp_rd.pop_front()));
            end
            prev_csn  = m_csn;
            prev_sck  = m_sck;
            prev_wreq = m_wreq;
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
        bus0.read      = rd & !sel;
        bus0.write     = wr & !sel;
        bus0.address   = sel ? 10'h0 : a;
        bus0.writedata = sel ? 32'h0 : d;
        bus1.read      = rd & sel;
        bus1.write     = wr & sel;
        bus1.address   = sel ? a : 10'h0;
        bus1.writedata = sel ? d : 32'h0;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        drive(rd, wr, a, d);
        for (int i = 0; i < 3000; i++) begin
            if (!m_wreq) break;
            @(negedge clk);
        end
        chk("accept_timeout", 72'(m_wreq), 72'(0));
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 10'h0, 32'h0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!m_wreq && m_csn) break;
        end
        chk("idle_timeout", 72'(m_wreq), 72'(0));
        @(negedge clk);
    endtask

    initial begin
        drive(1'b0, 1'b0, 10'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("reset_waitrequest", 72'(bus0.waitrequest), 72'(0));
        chk("reset_csn", 72'(csn0), 72'(1));
        chk("reset_sck", 72'(sck0), 72'(0));
        chk("reset_mosi", 72'(mosi0), 72'(0));
        chk("reset_readdata", 72'(bus0.readdata), 72'(0));
        chk("reset_rdv", 72'(bus0.readdatavalid), 72'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        push_frame(72'h800005DEADBEEF, 14, 2);
        req(1'b0, 1'b1, 10'h005, 32'hDEADBEEF);
        wait_idle();

        push_frame(72'h000005000000000000, 18, 2);
        exp_rd.push_back(32'hDEADBEEF);
        req(1'b1, 1'b0, 10'h005, 32'h0);
        wait_idle();

        push_frame(72'h8000100BADF00D, 14, 2);
        push_frame(72'h000010000000000000, 18, 2);
        exp_rd.push_back(32'h0BADF00D);
        req(1'b0, 1'b1, 10'h010, 32'h0BADF00D);
        req(1'b1, 1'b0, 10'h010, 32'h0);
        wait_idle();

        push_frame(72'h8003FF12345678, 14, 2);
        req(1'b1, 1'b1, 10'h3FF, 32'h12345678);
        push_frame(72'h0003FF000000000000, 18, 2);
        exp_rd.push_back(32'h12345678);
        req(1'b1, 1'b0, 10'h3FF, 32'h0);
        wait_idle();

        req(1'b1, 1'b0, 10'h005, 32'h0);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (rc == 5) break;
        end
        chk("reached_5th_rise", 72'(rc), 72'(5));
        rst_n = 1'b0;
        #1;
        chk("abort_csn", 72'(csn0), 72'(1));
        chk("abort_sck", 72'(sck0), 72'(0));
        chk("abort_mosi", 72'(mosi0), 72'(0));
        chk("abort_rdv", 72'(bus0.readdatavalid), 72'(0));
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_frame(72'h800021CAFE1234, 14, 2);
        req(1'b0, 1'b1, 10'h021, 32'hCAFE1234);
        push_frame(72'h000021000000000000, 18, 2);
        exp_rd.push_back(32'hCAFE1234);
        req(1'b1, 1'b0, 10'h021, 32'h0);
        wait_idle();

        sel = 1'b1;
        repeat (2) @(negedge clk);
        push_frame(72'h800007A5A5A5A5, 14, 1);
        req(1'b0, 1'b1, 10'h007, 32'hA5A5A5A5);
        push_frame(72'h000007000000000000, 18, 1);
        exp_rd.push_back(32'hA5A5A5A5);
        req(1'b1, 1'b0, 10'h007, 32'h0);
        wait_idle();
        repeat (4) @(negedge clk);

        chk("frames_outstanding", 72'(exp_fr.size()), 72'(0));
        chk("reads_outstanding", 72'(exp_rd.size()), 72'(0));
        chk("stray_events", 72'(stray), 72'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
